serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8, giving the operand width in bits; the legal range SHALL be 2 to 32.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled on the rising edge.
- a  input  WIDTH  minuend; captured only when start is accepted.
- b  input  WIDTH  subtrahend; captured only when start is accepted.
- b_in  input  1  borrow-in; captured only when start is accepted.
- busy  output  1  high while the block is processing bits.
- diff_bit  output  1  serial difference bit, LSB first.
- diff_valid  output  1  high in each cycle where diff_bit is a valid result bit.
- diff  output  WIDTH  parallel difference, final when done is high.
- b_out  output  1  final borrow-out.
- done  output  1  one-cycle completion pulse.
REQ-003 The design SHALL use one clock; reset SHALL be synchronous and active-high, named reset; the clock SHALL be named clock.

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-005 In IDLE or DONE, a rising edge with start=1 SHALL capture a, b and b_in into internal shift registers and the borrow flop, clear the bit counter, and enter RUN.
REQ-006 In RUN, start SHALL be ignored and the captured operands SHALL NOT change.
REQ-007 On each RUN edge, the block SHALL take a0/b0 from the LSBs of the shift registers and br from the borrow flop, and compute:
- d = a0 XOR b0 XOR br
- br_next = (NOT a0 AND b0) OR (NOT(a0 XOR b0) AND br)
REQ-008 On the same edge, the block SHALL register d to diff_bit, set diff_valid=1, shift d into diff from the MSB end, shift both operand registers right, update the borrow flop, and increment the counter.
REQ-009 If start is accepted at edge k, diff_valid SHALL be high after edges k+1 through k+WIDTH, for exactly WIDTH cycles, carrying bits 0 through WIDTH-1 in order.
REQ-010 At edge k+WIDTH, the FSM SHALL enter DONE; during that cycle, done=1, diff SHALL hold the complete WIDTH-bit difference (a - b - b_in) mod 2^WIDTH, and b_out SHALL be 1 exactly when a < b + b_in.
REQ-011 DONE SHALL last exactly one cycle and move to IDLE, or to RUN if start=1 on that edge, giving back-to-back operations with no idle cycle.
REQ-012 diff_valid SHALL be 0 in every cycle other than the WIDTH cycles defined in REQ-009.
REQ-013 diff and b_out SHALL hold their final values from DONE until the next accepted start; they SHALL be cleared on the edge that accepts start.
REQ-014 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-015 WIDTH-independent arithmetic SHALL use a counter of ceil(log2(WIDTH+1)) bits.
REQ-016 Counter wrap SHALL never occur.

Reset
REQ-017 With reset=1 on an edge, the FSM SHALL go to IDLE and busy, done, diff_valid, diff_bit, b_out, diff, the counter, the borrow flop and the operand registers SHALL all become 0.
REQ-018 Reset SHALL take priority over start, including reset mid-RUN, which SHALL abort the operation with no done pulse.
REQ-019 start sampled on the first edge after reset is deasserted SHALL be accepted normally.

Verification (WIDTH=8)
REQ-020 a=0x05, b=0x03, b_in=0, start for one cycle -> diff_bit sequence 0,1,0,0,0,0,0,0 with diff_valid high for 8 cycles; done one cycle with diff=0x02, b_out=0.
REQ-021 a=0x03, b=0x05, b_in=0 -> diff=0xFE, b_out=1.
REQ-022 a=0x00, b=0x00, b_in=1 -> diff=0xFF, b_out=1.
REQ-023 a=0xFF, b=0x00, b_in=1 -> diff=0xFE, b_out=0.
REQ-024 start re-pulsed with a=0x10 at the 4th RUN cycle -> the pulse is ignored and the result matches the first operands.
REQ-025 start held high through DONE -> the next operation starts with zero idle cycles.
REQ-026 reset asserted at the 3rd RUN cycle -> all outputs 0 next cycle, no done pulse.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first ripple-borrow over WIDTH cycles.
// Three-state control (IDLE/RUN/DONE) with a parallel result and a final borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_valid,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic br;
  logic a0, b0, d, br_nx;
  logic accept, last;

  assign a0     = a_sr[0];
  assign b0     = b_sr[0];
  assign d      = a0 ^ b0 ^ br;
  assign br_nx  = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_sr       <= '0;
      b_sr       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      diff_bit   <= 1'b0;
      diff_valid <= 1'b0;
      b_out      <= 1'b0;
    end else if (state == RUN) begin
      a_sr       <= a_sr >> 1;
      b_sr       <= b_sr >> 1;
      br         <= br_nx;
      cnt        <= cnt + 1'b1;
      diff       <= {d, diff[WIDTH-1:1]};
      diff_bit   <= d;
      diff_valid <= 1'b1;
      if (last) b_out <= br_nx;
    end else begin
      diff_valid <= 1'b0;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        br    <= b_in;
        cnt   <= '0;
        diff  <= '0;
        b_out <= 1'b0;
      end
    end
  end

endmodule
